instr_fetch_decode: RTL

- Upstream neighbour of the CPU control FSM.
- Owns the program counter and the instruction register.
- Drives the instruction-BRAM address and decodes the latched instruction into fields and the 2-bit instr_type the FSM branches on.
- Resolves Bcond/Jcond itself when the FSM pulses PC_enable, so the FSM treats type 11 as a one-cycle pass-through.

---
 rtl/instr_fetch_decode_if.sv | 11 +
 rtl/instr_fetch_decode.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode_if.sv
// Instruction-BRAM bus between the fetch/decode unit and the instruction memory.
// The fetch unit drives the address; the memory returns data one clock later.
interface instr_fetch_decode_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode: owns the PC and IR, drives the instruction-BRAM
// address, decodes the IR into fields and the 2-bit instr_type, and resolves
// Bcond/Jcond itself when PC_enable is pulsed. ADDR_WIDTH is expected in 8..16.
module instr_fetch_decode #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PC_enable,
  input  logic                  IR_enable,
  input  logic [4:0]            flags,
  input  logic [15:0]           jump_target,
  instr_fetch_decode_if.master  imem,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           instr,
  output logic [3:0]            opcode,
  output logic [3:0]            rdest,
  output logic [3:0]            ext,
  output logic [3:0]            rsrc,
  output logic [15:0]           imm_sext,
  output logic [1:0]            instr_type,
  output logic                  branch_taken
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_ir;
  logic                  r_branch_taken;

  logic                  w_is_bcond;
  logic                  w_is_jcond;
  logic                  w_cond_true;
  logic [1:0]            w_instr_type;

  // Flag positions within {C,L,F,Z,N}
  logic w_c, w_l, w_f, w_z, w_n;
  assign w_c = flags[4];
  assign w_l = flags[3];
  assign w_f = flags[2];
  assign w_z = flags[1];
  assign w_n = flags[0];

  // Field extraction is purely combinational from the IR
  assign instr        = r_ir;
  assign opcode       = r_ir[15:12];
  assign rdest        = r_ir[11:8];
  assign ext          = r_ir[7:4];
  assign rsrc         = r_ir[3:0];
  assign imm_sext     = {{8{r_ir[7]}}, r_ir[7:0]};
  assign instr_type   = w_instr_type;
  assign pc           = r_pc;
  assign imem.mem_addr = r_pc;
  assign branch_taken = r_branch_taken;

  assign w_is_bcond = (r_ir[15:12] == 4'b1100);
  assign w_is_jcond = (r_ir[15:12] == 4'b0100) && (r_ir[7:4] == 4'b1100);

  // Classify the latched instruction for the control FSM
  always_comb begin
    w_instr_type = 2'b00;
    if (r_ir == 16'h0000) begin
      w_instr_type = 2'b11;
    end else if (r_ir[15:12] == 4'b0100) begin
      case (r_ir[7:4])
        4'b0000: w_instr_type = 2'b10;
        4'b0100: w_instr_type = 2'b01;
        default: w_instr_type = 2'b11;
      endcase
    end else if (r_ir[15:12] == 4'b1100) begin
      w_instr_type = 2'b11;
    end
  end

  // Evaluate the branch/jump condition held in the rdest field
  always_comb begin
    w_cond_true = 1'b0;
    case (r_ir[11:8])
      4'b0000: w_cond_true = w_z;
      4'b0001: w_cond_true = !w_z;
      4'b0010: w_cond_true = w_c;
      4'b0011: w_cond_true = !w_c;
      4'b0100: w_cond_true = w_l;
      4'b0101: w_cond_true = !w_l;
      4'b0110: w_cond_true = w_n;
      4'b0111: w_cond_true = !w_n;
      4'b1000: w_cond_true = w_f;
      4'b1001: w_cond_true = !w_f;
      4'b1010: w_cond_true = !w_l && !w_z;
      4'b1011: w_cond_true = w_l || w_z;
      4'b1100: w_cond_true = !w_n && !w_z;
      4'b1101: w_cond_true = w_n || w_z;
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Instruction register: capture BRAM data when the FSM is in fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= 16'h0000;
    end else if (IR_enable) begin
      r_ir <= imem.mem_rdata;
    end
  end

  // PC update: redirect on a taken branch/jump, else advance; decision uses pre-edge IR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc           <= RESET_PC;
      r_branch_taken <= 1'b0;
    end else if (PC_enable) begin
      if (w_is_bcond && w_cond_true) begin
        r_pc           <= r_pc + imm_sext[ADDR_WIDTH-1:0];
        r_branch_taken <= 1'b1;
      end else if (w_is_jcond && w_cond_true) begin
        r_pc           <= jump_target[ADDR_WIDTH-1:0];
        r_branch_taken <= 1'b1;
      end else begin
        r_pc           <= r_pc + PC_ONE;
        r_branch_taken <= 1'b0;
      end
    end else begin
      r_branch_taken <= 1'b0;
    end
  end

endmodule
